// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: glyph patterns,
// FSM state encoding and the digit-enable one-hot-low check.
package seg7_pkg;

    // Segment patterns a..g (bit6 = a), active low
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Capture FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // True when exactly one of the low n bits of an is 0 (n <= 32)
    function automatic logic onehot_low(input logic [31:0] an, input int n);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && !an[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Reverse lookup from an active-low a..g segment pattern to a hex nibble.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_legal,
    output logic       is_blank
);

    // Match the pattern against every glyph; anything unlisted is illegal
    always_comb begin
        nibble   = 4'h0;
        is_legal = 1'b1;
        is_blank = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                is_legal = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures each digit of a multiplexed active-low 7-segment bus once its
// pattern has been stable long enough, and decodes it back to hex + DP.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS-1:0]         an,
    input  logic [7:0]                    seg,
    output logic [4*NUM_DIGITS-1:0]       hex_out,
    output logic [NUM_DIGITS-1:0]         dp_out,
    output logic [NUM_DIGITS-1:0]         valid,
    output logic                          frame_done,
    output logic                          err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [NUM_DIGITS-1:0]   r_an_q, r_an_d;
    logic [7:0]              r_seg_q, r_seg_d;
    logic                    chg_q, chg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        err_digit_q, err_digit_d;

    logic                    onehot;
    logic                    capture;
    logic [IDX_W-1:0]        dig;
    logic [3:0]              dec_nibble;
    logic                    dec_legal;
    logic                    dec_blank;

    seg7_to_hex u_dec (
        .seg      (r_seg_q[6:0]),
        .nibble   (dec_nibble),
        .is_legal (dec_legal),
        .is_blank (dec_blank)
    );

    // Input register plus stability counter; the counter is updated on the same
    // edge as the input register so it always counts samples of the current r_*
    always_comb begin
        r_an_d  = an;
        r_seg_d = seg;
        chg_d   = ({an, seg} != {r_an_q, r_seg_q});
        if (chg_d)
            cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    // Selected digit index and one-hot-low qualification of the registered enables
    always_comb begin
        onehot = onehot_low(32'(r_an_q), NUM_DIGITS);
        dig    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) dig = IDX_W'(i);
        end
    end

    // FSM and output update; outputs are written on the edge that enters
    // CAPTURE so a stable pattern lands exactly STABLE_CYCLES edges after it
    // was first sampled
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        hex_d       = hex_q;
        dp_d        = dp_q;
        valid_d     = valid_q;
        seen_d      = seen_q;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        case (state_q)
            ST_IDLE: begin
                if (onehot) state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (!onehot) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_CAPTURE;
                    capture = 1'b1;
                end
            end
            default: begin
                // CAPTURE and HOLD: wait for the next change of the inputs
                if (chg_q)
                    state_d = onehot ? ST_TRACK : ST_IDLE;
                else
                    state_d = ST_HOLD;
            end
        endcase

        if (capture) begin
            dp_d[dig]    = ~r_seg_q[7];
            valid_d[dig] = dec_legal;
            if (dec_legal) hex_d[4*dig +: 4] = dec_nibble;
            if (!dec_legal && !dec_blank) begin
                err_d       = 1'b1;
                err_digit_d = dig;
            end
            seen_d[dig] = 1'b1;
            if (seen_d == ALL_SEEN) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_q      <= '0;
            r_seg_q     <= '0;
            chg_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            hex_q       <= '0;
            dp_q        <= '0;
            valid_q     <= '0;
            seen_q      <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            r_an_q      <= r_an_d;
            r_seg_q     <= r_seg_d;
            chg_q       <= chg_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign hex_out    = hex_q;
    assign dp_out     = dp_q;
    assign valid      = valid_q;
    assign frame_done = frame_q;
    assign err        = err_q;
    assign err_digit  = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture with a run-length reference model.
module tb_seg7_scan_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_digit;

    seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .seg        (seg),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err),
        .err_digit  (err_digit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_frames = 0;
    int dut_errs = 0;

    // Reference model state
    logic [6:0]  glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [15:0] exp_hex;
    logic [3:0]  exp_dp, exp_valid, exp_seen;
    logic [1:0]  exp_err_digit;
    int          exp_frames = 0;
    int          exp_errs = 0;
    logic [11:0] run_val;
    int          run_len;

    task automatic model_reset();
        exp_hex = '0; exp_dp = '0; exp_valid = '0; exp_seen = '0;
        exp_err_digit = '0; run_val = '0; run_len = 0;
    endtask

    // One clock edge seen by the model: the pattern that has been sitting in the
    // input register for exactly SC edges is captured now; then the new sample enters.
    task automatic model_edge(input logic [3:0] a, input logic [7:0] s);
        logic [3:0] ra;
        logic [7:0] rs;
        int zeros, d, nib;
        ra = run_val[11:8];
        rs = run_val[7:0];
        zeros = 0; d = 0;
        for (int i = 0; i < 4; i++) if (!ra[i]) begin zeros++; d = i; end
        if (run_len == SC && zeros == 1) begin
            nib = -1;
            for (int g = 0; g < 16; g++) if (glyph[g] == rs[6:0]) nib = g;
            exp_dp[d] = ~rs[7];
            if (nib >= 0) begin
                exp_hex[4*d +: 4] = 4'(nib);
                exp_valid[d] = 1'b1;
            end else begin
                exp_valid[d] = 1'b0;
                if (rs[6:0] != 7'h7F) begin
                    exp_errs++;
                    exp_err_digit = 2'(d);
                end
            end
            exp_seen[d] = 1'b1;
            if (exp_seen == 4'hF) begin
                exp_frames++;
                exp_seen = '0;
            end
        end
        if ({a, s} == run_val) run_len++;
        else begin
            run_val = {a, s};
            run_len = 1;
        end
    endtask

    // Drive one cycle (called at a negedge), returns at the following negedge
    task automatic cycle(input logic [3:0] a, input logic [7:0] s);
        an = a;
        seg = s;
        @(posedge clk);
        model_edge(a, s);
        @(negedge clk);
        if (frame_done === 1'b1) dut_frames++;
        if (err === 1'b1) dut_errs++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) cycle(a, s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an = 4'hF;
        seg = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        an = 4'hF;
        seg = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        checks++; if (hex_out !== 16'h0) begin errors++; $display("FAIL reset_hex: got %h expected 0000", hex_out); end
        checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL reset_dp: got %b expected 0000", dp_out); end
        checks++; if (valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b expected 0000", valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (err_digit !== 2'd0) begin errors++; $display("FAIL reset_err_digit: got %0d expected 0", err_digit); end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_steady_glyph();
        hold(4'hF, 8'hFF, 3);
        hold(4'b1110, {1'b0, glyph[3]}, 3);
        hold(4'hF, 8'hFF, 2);
        checks++; if (valid[0] !== 1'b0 || hex_out[3:0] !== 4'h0) begin errors++;
            $display("FAIL steady_short: got valid0=%b hex0=%h expected 0/0", valid[0], hex_out[3:0]); end
        hold(4'b1110, {1'b0, glyph[3]}, 4);
        checks++; if (valid[0] !== 1'b0) begin errors++;
            $display("FAIL steady_early: got valid0=%b expected 0 before edge k+4", valid[0]); end
        cycle(4'b1110, {1'b0, glyph[3]});
        checks++; if (hex_out[3:0] !== 4'h3 || valid[0] !== 1'b1 || dp_out[0] !== 1'b1) begin errors++;
            $display("FAIL steady_capture: got hex0=%h valid0=%b dp0=%b expected 3/1/1", hex_out[3:0], valid[0], dp_out[0]); end
        checks++; if (hex_out !== exp_hex || valid !== exp_valid || dp_out !== exp_dp) begin errors++;
            $display("FAIL steady_model: got %h/%b/%b expected %h/%b/%b", hex_out, valid, dp_out, exp_hex, exp_valid, exp_dp); end
    endtask

    task automatic test_full_scan();
        int f0;
        logic [3:0]  ans  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int          gidx [4] = '{10, 11, 12, 13};
        f0 = dut_frames;
        for (int d = 0; d < 3; d++) hold(ans[d], {1'b1, glyph[gidx[d]]}, 6);
        checks++; if (dut_frames !== f0) begin errors++;
            $display("FAIL scan_early_frame: got %0d pulses expected 0", dut_frames - f0); end
        hold(ans[3], {1'b1, glyph[13]}, 5);
        checks++; if (dut_frames !== f0 + 1 || frame_done !== 1'b1) begin errors++;
            $display("FAIL scan_frame_edge: got %0d pulses frame_done=%b expected 1/1", dut_frames - f0, frame_done); end
        cycle(ans[3], {1'b1, glyph[13]});
        checks++; if (frame_done !== 1'b0) begin errors++;
            $display("FAIL scan_frame_width: got %b expected 0", frame_done); end
        checks++; if (hex_out !== 16'hDCBA || valid !== 4'hF || dp_out !== 4'h0) begin errors++;
            $display("FAIL scan_result: got %h/%b/%b expected dcba/1111/0000", hex_out, valid, dp_out); end
        checks++; if (dut_frames !== exp_frames) begin errors++;
            $display("FAIL scan_frame_count: got %0d expected %0d", dut_frames, exp_frames); end
    endtask

    task automatic test_reset_hold();
        checks++; if (valid !== 4'hF) begin errors++;
            $display("FAIL hold_pre_valid: got %b expected 1111", valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (hex_out !== 16'h0 || dp_out !== 4'h0 || valid !== 4'h0 ||
                      frame_done !== 1'b0 || err !== 1'b0 || err_digit !== 2'd0) begin errors++;
            $display("FAIL async_reset: got %h/%b/%b/%b/%b/%0d expected all 0", hex_out, dp_out, valid, frame_done, err, err_digit); end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_bad_pattern();
        int e0;
        hold(4'b1101, {1'b1, glyph[11]}, 6);
        e0 = dut_errs;
        hold(4'b1101, {1'b1, 7'b1010101}, 5);
        checks++; if (dut_errs !== e0 + 1 || err_digit !== 2'd1) begin errors++;
            $display("FAIL bad_err: got %0d pulses err_digit=%0d expected 1/1", dut_errs - e0, err_digit); end
        checks++; if (valid[1] !== 1'b0 || hex_out[7:4] !== 4'hB) begin errors++;
            $display("FAIL bad_outputs: got valid1=%b hex1=%h expected 0/b", valid[1], hex_out[7:4]); end
        hold(4'b1101, {1'b1, glyph[5]}, 6);
        e0 = dut_errs;
        hold(4'b1101, 8'hFF, 6);
        checks++; if (valid[1] !== 1'b0 || hex_out[7:4] !== 4'h5 || dut_errs !== e0) begin errors++;
            $display("FAIL blank: got valid1=%b hex1=%h errs=%0d expected 0/5/0", valid[1], hex_out[7:4], dut_errs - e0); end
        checks++; if (dut_errs !== exp_errs || err_digit !== exp_err_digit) begin errors++;
            $display("FAIL bad_model: got %0d/%0d expected %0d/%0d", dut_errs, err_digit, exp_errs, exp_err_digit); end
    endtask

    task automatic test_ghosting();
        logic [15:0] h0;
        logic [3:0]  v0, d0;
        int          f0, e0;
        h0 = hex_out; v0 = valid; d0 = dp_out; f0 = dut_frames; e0 = dut_errs;
        hold(4'b1100, {1'b0, glyph[7]}, 10);
        checks++; if (hex_out !== h0 || valid !== v0 || dp_out !== d0 || dut_frames !== f0 || dut_errs !== e0) begin errors++;
            $display("FAIL ghost: got %h/%b/%b expected %h/%b/%b with no pulses", hex_out, valid, dp_out, h0, v0, d0); end
        hold(4'b1011, {1'b1, glyph[9]}, 2);
        cycle(4'b1011, {1'b1, glyph[1]});
        hold(4'b1011, {1'b1, glyph[9]}, 4);
        checks++; if (valid[2] !== 1'b0) begin errors++;
            $display("FAIL glitch_delay: got valid2=%b expected 0", valid[2]); end
        cycle(4'b1011, {1'b1, glyph[9]});
        checks++; if (valid[2] !== 1'b1 || hex_out[11:8] !== 4'h9) begin errors++;
            $display("FAIL glitch_capture: got valid2=%b hex2=%h expected 1/9", valid[2], hex_out[11:8]); end
    endtask

    task automatic test_repeat_digit();
        int f0;
        do_reset();
        f0 = dut_frames;
        hold(4'b1110, {1'b1, glyph[1]}, 6);
        hold(4'hF, 8'hFF, 1);
        hold(4'b1110, {1'b1, glyph[2]}, 6);
        checks++; if (dut_frames !== f0 || hex_out[3:0] !== 4'h2) begin errors++;
            $display("FAIL repeat_first: got %0d pulses hex0=%h expected 0/2", dut_frames - f0, hex_out[3:0]); end
        hold(4'b1101, {1'b1, glyph[4]}, 6);
        hold(4'b1011, {1'b1, glyph[6]}, 6);
        checks++; if (dut_frames !== f0) begin errors++;
            $display("FAIL repeat_mid: got %0d pulses expected 0", dut_frames - f0); end
        hold(4'b0111, {1'b1, glyph[8]}, 6);
        hold(4'hF, 8'hFF, 3);
        checks++; if (dut_frames !== f0 + 1 || hex_out !== 16'h8642) begin errors++;
            $display("FAIL repeat_frame: got %0d pulses hex=%h expected 1/8642", dut_frames - f0, hex_out); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] s;
        int         r;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0) a = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
            else a = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            if (r < 14) s = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            else if (r < 17) s = {1'($urandom_range(0, 1)), 7'h7F};
            else s = 8'($urandom_range(0, 255));
            hold(a, s, $urandom_range(1, 7));
            checks++; if (hex_out !== exp_hex || valid !== exp_valid || dp_out !== exp_dp) begin errors++;
                $display("FAIL rand_outputs[%0d]: got %h/%b/%b expected %h/%b/%b", n, hex_out, valid, dp_out, exp_hex, exp_valid, exp_dp); end
            checks++; if (dut_frames !== exp_frames || dut_errs !== exp_errs || err_digit !== exp_err_digit) begin errors++;
                $display("FAIL rand_events[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", n, dut_frames, dut_errs, err_digit, exp_frames, exp_errs, exp_err_digit); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        rst = 1'b1;
        an = 4'hF;
        seg = 8'hFF;
        test_reset();
        test_steady_glyph();
        test_full_scan();
        test_reset_hold();
        test_bad_pattern();
        test_ghosting();
        test_repeat_digit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiving end of the team's multiplexed 7-segment display interface.
- Watches an active-low digit-enable bus and an active-low segment bus, both in the same clock domain.
- Waits until each digit's segment pattern has been stable for a set number of cycles, then decodes it back to a hex nibble plus a decimal-point flag.
- Used for loopback checking of display drivers on the board and in simulation.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines).
- STABLE_CYCLES, 4, consecutive identical samples (≥2) required before a digit is captured.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  NUM_DIGITS  digit enables, active low; exactly one low bit selects a digit.
- seg  input  8  seg[6:0] = segments a..g (bit6 = a), active low; seg[7] = DP, active low.
- hex_out  output  4*NUM_DIGITS  decoded nibble per digit; digit i occupies bits [4i+3:4i].
- dp_out  output  NUM_DIGITS  1 = DP lit on that digit.
- valid  output  NUM_DIGITS  1 = the last capture of that digit decoded to a legal hex glyph.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err  output  1  one-cycle pulse when a captured pattern is neither a legal glyph nor blank.
- err_digit  output  clog2(NUM_DIGITS)  index of the digit that raised err; holds its value between errors.

Behaviour:
- Reset (async, rst=1): all outputs, registers and counters go to 0; FSM goes to IDLE.
- Input stage: an and seg are registered once (r_an, r_seg). All decisions use the registered values.
- Stability counter stab_cnt (saturating):
  - loads 1 when {r_an, r_seg} differs from the previous cycle's value;
  - otherwise increments.
- FSM states:
  - IDLE: r_an is not one-hot-low (all high, or several low). Stays here; stab_cnt is irrelevant. Goes to TRACK as soon as r_an is one-hot-low.
  - TRACK: goes to CAPTURE when stab_cnt == STABLE_CYCLES with no input change. Goes to IDLE if r_an stops being one-hot-low. Stays in TRACK on any change to a different one-hot value.
  - CAPTURE: lasts one cycle. Writes the outputs for the selected digit d, then goes to HOLD.
  - HOLD: no further capture. Any change of r_an or r_seg goes to TRACK if the new r_an is one-hot-low, otherwise to IDLE.
- Latency: a pattern first sampled into r_* at edge k and held unchanged updates the outputs at edge k+STABLE_CYCLES.
- Decode table (seg[6:0] → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B
  - 0110001→C, 1000010→D, 0110000→E, 0111000→F
- Outputs written on capture of digit d:
  - Legal glyph: hex_out[d] = nibble, valid[d] = 1.
  - Blank (1111111): valid[d] = 0, hex_out[d] unchanged, no err.
  - Any other pattern: valid[d] = 0, hex_out[d] unchanged, err = 1 for one cycle, err_digit = d.
  - In every case dp_out[d] = ~r_seg[7].
- Frame tracking: seen mask bit d is set on each capture. On the edge where the mask becomes all ones, frame_done pulses for one cycle and the mask clears in that same edge. Re-capturing an already-seen digit does not pulse frame_done.
- Simultaneous events: err and frame_done may pulse in the same cycle.
- Reset during any state aborts immediately; no partial capture survives.

Decomposition:
- Package seg7_pkg holds:
  - glyph constants SEG_0..SEG_F and SEG_BLANK;
  - the FSM state encoding {IDLE, TRACK, CAPTURE, HOLD};
  - a one-hot-low check function.
- The same glyph constants are the source of truth for the team's existing hex-to-segment encoder.
- Sub-module seg7_to_hex: combinational reverse lookup with seg[6:0] in, and nibble, is_legal, is_blank out. It is instantiated once on r_seg.

Test Plan:
- Reset mid-HOLD with valid = 4'b1111: assert rst → all outputs 0 asynchronously, before the next clock edge.
- Steady glyph: an=1110, seg=8'b0_0000110, held for 4 cycles → at edge k+4, hex_out[3:0] = 3, valid[0] = 1, dp_out[0] = 1. Held for only 3 cycles → no change.
- Full scan: digits 0..3 show A, b, C, d with seg[7]=1, each held 6 cycles → hex_out = 16'hDCBA, valid = 4'hF, dp_out = 0, exactly one frame_done on the digit-3 capture.
- Bad pattern: an=1101, seg[6:0]=1010101 held 4 cycles → err pulses 1 cycle, err_digit = 1, valid[1] = 0, hex_out[7:4] unchanged. Blank 1111111 → valid[1] = 0 with no err.
- Ghosting: an=1100 (two digits low) held 10 cycles → no capture, FSM stays IDLE. Then a glitch that changes seg mid-count → stab_cnt reloads and capture is delayed by the full STABLE_CYCLES.
- Repeat digit: capture digit 0 twice, then digits 1..3 → frame_done only after digit 3, and exactly once.
